// File: rtl/sigmoid_taylor_pipe.sv
// Pipelined fixed-point sigmoid using a base-2 decomposition, with valid/ready flow control.
// Define SIGMOID_TAYLOR_QUAD_EN to add a second-order correction stage (latency 5 instead of 4).
`timescale 1ns/1ps
module sigmoid_taylor_pipe #(
    parameter int IW = 12,
    parameter int IF = 8,
    parameter int OW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] f_x,
    output logic          f_sat
);

    localparam int UW = IW + 1;   // (|x| * 23) >> 4 never exceeds IW+1 bits
    localparam int NW = UW - IF;  // integer part n of t*log2(e)
    localparam int MW = IF + 1;   // mantissa m, Q1.IF
    localparam int YW = OW + 1;   // shifted mantissa before the final subtract
`ifdef SIGMOID_TAYLOR_QUAD_EN
    localparam int NST = 5;
`else
    localparam int NST = 4;
`endif

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // One valid bit per stage; the whole pipe advances or stalls as a unit
    logic [NST-1:0] vld_reg;
    logic [NST-1:0] vld_next;

    genvar gi;
    generate
        for (gi = 0; gi < NST; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                assign vld_next[gi] = in_valid;
            end else begin : g_tail
                assign vld_next[gi] = vld_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
        end else if (en) begin
            vld_reg <= vld_next;
        end
    end

    assign out_valid = vld_reg[NST-1];

    // S1: sign and magnitude; -2^(IW-1) maps to 2^(IW-1) as an unsigned value
    logic          s1_sgn_reg;
    logic [IW-1:0] s1_abs_reg;
    logic [IW-1:0] s1_abs_next;

    assign s1_abs_next = x[IW-1] ? ((~x) + IW'(1)) : x;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sgn_reg <= 1'b0;
            s1_abs_reg <= '0;
        end else if (en) begin
            s1_sgn_reg <= x[IW-1];
            s1_abs_reg <= s1_abs_next;
        end
    end

    // S2: u = |x| * 23/16 (~log2 e), split into integer n and fraction phi
    logic          s2_sgn_reg;
    logic [NW-1:0] s2_n_reg;
    logic [IF-1:0] s2_phi_reg;
    logic [UW-1:0] s2_u_next;

    assign s2_u_next = UW'(((IW+5)'(s1_abs_reg) * (IW+5)'(23)) >> 4);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sgn_reg <= 1'b0;
            s2_n_reg   <= '0;
            s2_phi_reg <= '0;
        end else if (en) begin
            s2_sgn_reg <= s1_sgn_reg;
            s2_n_reg   <= s2_u_next[UW-1:IF];
            s2_phi_reg <= s2_u_next[IF-1:0];
        end
    end

    logic          pre_sgn;
    logic [NW-1:0] pre_n;
    logic [IF-1:0] pre_phi;
    logic [MW-1:0] s3_m;

`ifdef SIGMOID_TAYLOR_QUAD_EN
    // S3a: chord correction c = phi*(1-phi)/8 pulls the linear 2^-phi down to the curve
    logic          s3a_sgn_reg;
    logic [NW-1:0] s3a_n_reg;
    logic [IF-1:0] s3a_phi_reg;
    logic [IF-1:0] s3a_c_reg;
    logic [IF-1:0] s3a_c_next;

    assign s3a_c_next = IF'(((2*IF+1)'(s2_phi_reg)
                            * ((2*IF+1)'(1 << IF) - (2*IF+1)'(s2_phi_reg))) >> (IF + 3));

    always_ff @(posedge clk) begin
        if (rst) begin
            s3a_sgn_reg <= 1'b0;
            s3a_n_reg   <= '0;
            s3a_phi_reg <= '0;
            s3a_c_reg   <= '0;
        end else if (en) begin
            s3a_sgn_reg <= s2_sgn_reg;
            s3a_n_reg   <= s2_n_reg;
            s3a_phi_reg <= s2_phi_reg;
            s3a_c_reg   <= s3a_c_next;
        end
    end

    assign pre_sgn = s3a_sgn_reg;
    assign pre_n   = s3a_n_reg;
    assign pre_phi = s3a_phi_reg;
    assign s3_m    = MW'(1 << IF) - MW'(pre_phi >> 1) - MW'(s3a_c_reg);
`else
    assign pre_sgn = s2_sgn_reg;
    assign pre_n   = s2_n_reg;
    assign pre_phi = s2_phi_reg;
    assign s3_m    = MW'(1 << IF) - MW'(pre_phi >> 1);
`endif

    // S3: y = m * 2^-(n+1) scaled to OW fractional bits, truncating
    logic          s3_sgn_reg;
    logic [YW-1:0] s3_y_reg;
    logic [NW:0]   s3_sh;
    logic [YW-1:0] s3_y_next;

    assign s3_sh     = (NW+1)'(pre_n) + (NW+1)'(1);
    assign s3_y_next = (32'(s3_sh) > OW) ? '0 : ((YW'(s3_m) << (OW - IF)) >> s3_sh);

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_sgn_reg <= 1'b0;
            s3_y_reg   <= '0;
        end else if (en) begin
            s3_sgn_reg <= pre_sgn;
            s3_y_reg   <= s3_y_next;
        end
    end

    // S4: positive inputs mirror around 1/2; y == 0 would give exactly 1.0, so clamp
    logic [OW-1:0] f_x_reg;
    logic          f_sat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_x_reg   <= '0;
            f_sat_reg <= 1'b0;
        end else if (en) begin
            if (s3_sgn_reg) begin
                f_x_reg   <= OW'(s3_y_reg);
                f_sat_reg <= 1'b0;
            end else if (s3_y_reg == '0) begin
                f_x_reg   <= '1;
                f_sat_reg <= 1'b1;
            end else begin
                f_x_reg   <= OW'(YW'(1 << OW) - s3_y_reg);
                f_sat_reg <= 1'b0;
            end
        end
    end

    assign f_x   = f_x_reg;
    assign f_sat = f_sat_reg;

endmodule

// File: tb/tb_sigmoid_taylor_pipe.sv
// Directed bench for sigmoid_taylor_pipe: vector table, stalled stream, and mid-stream reset.
`timescale 1ns/1ps
module tb_sigmoid_taylor_pipe;

    localparam int IW = 12;
    localparam int IF = 8;
    localparam int OW = 12;
`ifdef SIGMOID_TAYLOR_QUAD_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int NV = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] x = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] f_x;
    logic          f_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int xv;
        int fx;
        bit sat;
    } vec_t;

    vec_t vecs[NV];

    sigmoid_taylor_pipe #(.IW(IW), .IF(IF), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_x       (f_x),
        .f_sat     (f_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int xv, input int f_lin, input int f_quad, input bit sat);
        vec_t v;
        v.xv = xv;
`ifdef SIGMOID_TAYLOR_QUAD_EN
        v.fx = f_quad;
`else
        v.fx = f_lin;
`endif
        v.sat = sat;
        return v;
    endfunction

    // Single sample: measure latency and compare the result
    task automatic run_one(input vec_t v);
        int cyc;
        bit seen;
        in_valid = 1'b1;
        x        = 12'(v.xv);
        cyc      = 0;
        seen     = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        $display("vec x=%0d f_x=%0d f_sat=%0d latency=%0d", v.xv, f_x, f_sat, cyc);
        check("latency", cyc, LAT);
        check("f_x", int'(f_x), v.fx);
        check("f_sat", int'(f_sat), int'(v.sat));
    endtask

    initial begin
        int got;
        int idx;
        int ghost;
        bit prev_stall;
        int prev_fx;

        vecs[0]  = mk(    0, 2048, 2048, 1'b0);
        vecs[1]  = mk( -256,  800,  772, 1'b0);
        vecs[2]  = mk(  256, 3296, 3324, 1'b0);
        vecs[3]  = mk( -128, 1312, 1264, 1'b0);
        vecs[4]  = mk(  128, 2784, 2832, 1'b0);
        vecs[5]  = mk( -512,  288,  282, 1'b0);
        vecs[6]  = mk(  512, 3808, 3814, 1'b0);
        vecs[7]  = mk(   -1, 2048, 2048, 1'b0);
        vecs[8]  = mk(    1, 2048, 2048, 1'b0);
        vecs[9]  = mk(-1024,   40,   38, 1'b0);
        vecs[10] = mk( 1024, 4056, 4058, 1'b0);
        vecs[11] = mk(-2048,    0,    0, 1'b0);
        vecs[12] = mk( 2047, 4095, 4095, 1'b1);

        // Reset held three cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_f_x", int'(f_x), 0);
        check("rst_f_sat", int'(f_sat), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);

        for (int i = 0; i < NV; i++) begin
            run_one(vecs[i]);
        end

        // Back-to-back stream of 8, consumer stalls for 3 cycles while outputs are valid
        got        = 0;
        idx        = 0;
        prev_stall = 1'b0;
        prev_fx    = 0;
        for (int t = 0; t < 100 && got < 8; t++) begin
            @(negedge clk);
            in_valid = (idx < 8);
            if (idx < 8) x = 12'(vecs[idx].xv);
            out_ready = !(t >= 6 && t <= 8);
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", int'(in_ready), 0);
                if (prev_stall) check("stall_hold", int'(f_x), prev_fx);
                prev_stall = 1'b1;
                prev_fx    = int'(f_x);
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                $display("stream out #%0d f_x=%0d", got, f_x);
                check("stream_f_x", int'(f_x), vecs[got].fx);
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        check("stream_count", got, 8);
        check("stream_accepted", idx, 8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with three samples in flight: none may ever emerge
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = 12'(vecs[k + 1].xv);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("flush_out_valid", int'(out_valid), 0);
        rst   = 1'b0;
        ghost = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        $display("flush ghost outputs=%0d", ghost);
        check("flush_ghosts", ghost, 0);

        // Pipe still usable after the flush
        run_one(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
